// File: rtl/data_sram_responder.sv
// Data SRAM responder: single-port word array behind a one-entry store buffer.
// Reads have one cycle of latency. A read that hits the buffered index is
// forwarded from the buffer. Out-of-range accesses raise a sticky error flag
// and capture the address of the first error.
// Optional feature: define DATA_SRAM_ALIGN_CHECK_EN to treat addr[1:0]!=0 as
// an access error.
module data_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] wr_cnt,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];

  logic              sb_valid_q, sb_valid_d;
  logic [ADDR_W-1:0] sb_idx_q, sb_idx_d;
  logic [31:0]       sb_data_q, sb_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              in_range;
  logic              acc_err;
  logic [ADDR_W-1:0] idx;
  logic              wr_acc;
  logic              rd;
  logic              commit;

`ifndef DATA_SRAM_ALIGN_CHECK_EN
  // Byte-lane bits are deliberately ignored when alignment is not checked.
  logic unused_lsb;
  assign unused_lsb = ^data_sram_addr[1:0];
`endif

  // Decode the single access of this cycle and decide what the buffer does.
  always_comb begin
    in_range = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    acc_err  = !in_range || (data_sram_addr[1:0] != 2'b00);
`else
    acc_err  = !in_range;
`endif
    idx      = data_sram_addr[ADDR_W+1:2];
    wr_acc   = data_sram_we && !acc_err;
    rd       = !data_sram_we;
    // A pending entry drains on any read, or when a new accepted write
    // needs the buffer slot. A dropped write leaves the entry untouched.
    commit   = sb_valid_q && (wr_acc || rd);
  end

  // Next-state for buffer, read data, write counter and error capture.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_idx_d   = sb_idx_q;
    sb_data_d  = sb_data_q;
    rdata_d    = rdata_q;
    wr_cnt_d   = wr_cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    if (wr_acc) begin
      sb_valid_d = 1'b1;
      sb_idx_d   = idx;
      sb_data_d  = data_sram_wdata;
      if (wr_cnt_q != 16'hFFFF) begin
        wr_cnt_d = wr_cnt_q + 16'd1;
      end
    end else if (rd) begin
      sb_valid_d = 1'b0;
    end

    if (rd) begin
      if (acc_err) begin
        rdata_d = 32'h0;
      end else if (sb_valid_q && (sb_idx_q == idx)) begin
        rdata_d = sb_data_q;
      end else begin
        rdata_d = mem[idx];
      end
    end

    if (acc_err) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = data_sram_addr;
      end
    end
  end

  // Control and output registers; reset discards any buffered write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid_q <= 1'b0;
      rdata_q    <= 32'h0;
      wr_cnt_q   <= 16'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      sb_valid_q <= sb_valid_d;
      rdata_q    <= rdata_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Buffer payload; only meaningful while sb_valid_q is set.
  always_ff @(posedge clk) begin
    sb_idx_q  <= sb_idx_d;
    sb_data_q <= sb_data_d;
  end

  // Array write port, fed only by store-buffer commits; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[sb_idx_q] <= sb_data_q;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign wr_cnt          = wr_cnt_q;
  assign err             = err_q;
  assign err_addr        = err_addr_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder; expected values are hand-computed.
// Build with +define+DATA_SRAM_ALIGN_CHECK_EN to exercise the alignment check.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] wr_cnt;
  logic        err;
  logic [31:0] err_addr;

  int n_chk  = 0;
  int n_pass = 0;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .wr_cnt          (wr_cnt),
    .err             (err),
    .err_addr        (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access for one clock; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge with an idle bus, release away from the edge.
  task automatic do_reset();
    we    = 1'b0;
    addr  = 32'h1c00_0000;
    wdata = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_rdata",    rdata, 32'h0);
    chk("rst_wr_cnt",   {16'h0, wr_cnt}, 32'h0);
    chk("rst_err",      {31'h0, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    reset = 1'b0;

    // Pre-fill the words used later with zero, drain the buffer, then reset.
    cyc(1'b1, 32'h1c00_0030, 32'h0);
    cyc(1'b1, 32'h1c00_0008, 32'h0);
    cyc(1'b1, 32'h1c00_0000, 32'h0);
    cyc(1'b0, 32'h1c00_0000, 32'h0);
    chk("prefill_fwd", rdata, 32'h0);
    chk("prefill_cnt", {16'h0, wr_cnt}, 32'd3);
    do_reset();
    chk("rst2_cnt", {16'h0, wr_cnt}, 32'h0);

    // Write then forwarded read
    cyc(1'b1, 32'h1c00_0010, 32'hdead_beef);
    chk("w1_cnt", {16'h0, wr_cnt}, 32'd1);
    chk("w1_rdata_hold", rdata, 32'h0);
    cyc(1'b0, 32'h1c00_0010, 32'h0);
    chk("fwd_rdata", rdata, 32'hdead_beef);
    chk("fwd_cnt", {16'h0, wr_cnt}, 32'd1);

    // Back-to-back writes to the same word, last one wins
    do_reset();
    cyc(1'b1, 32'h1c00_0020, 32'h1111_1111);
    cyc(1'b1, 32'h1c00_0020, 32'h2222_2222);
    chk("b2b_rdata_hold", rdata, 32'h0);
    cyc(1'b0, 32'h1c00_0008, 32'h0);
    chk("idle_rd", rdata, 32'h0);
    cyc(1'b0, 32'h1c00_0020, 32'h0);
    chk("b2b_rdata", rdata, 32'h2222_2222);
    chk("b2b_cnt", {16'h0, wr_cnt}, 32'd2);

    // Buffer commits on a read to another word, then read from the array
    do_reset();
    cyc(1'b1, 32'h1c00_0004, 32'ha5a5_a5a5);
    cyc(1'b0, 32'h1c00_0008, 32'h0);
    chk("other_rd", rdata, 32'h0);
    cyc(1'b0, 32'h1c00_0004, 32'h0);
    chk("array_rd", rdata, 32'ha5a5_a5a5);
    chk("array_cnt", {16'h0, wr_cnt}, 32'd1);

    // Out-of-range write and read
    do_reset();
    cyc(1'b1, 32'h0000_0100, 32'h1234_5678);
    chk("oor_w_err", {31'h0, err}, 32'd1);
    chk("oor_w_eaddr", err_addr, 32'h0000_0100);
    chk("oor_w_cnt", {16'h0, wr_cnt}, 32'h0);
    cyc(1'b0, 32'h1fff_0000, 32'h0);
    chk("oor_r_rdata", rdata, 32'h0);
    chk("oor_r_eaddr", err_addr, 32'h0000_0100);
    chk("oor_r_err", {31'h0, err}, 32'd1);

    // Buffered write discarded by a reset arriving in the next cycle
    do_reset();
    cyc(1'b1, 32'h1c00_0030, 32'h0000_0005);
    we    = 1'b0;
    reset = 1'b1;
    #2;
    chk("async_rst_cnt", {16'h0, wr_cnt}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 32'h1c00_0030, 32'h0);
    chk("discard_rdata", rdata, 32'h0);
    chk("discard_cnt", {16'h0, wr_cnt}, 32'h0);

    // Misaligned write
    do_reset();
    cyc(1'b1, 32'h1c00_0002, 32'h0000_0077);
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    chk("mis_err", {31'h0, err}, 32'd1);
    chk("mis_eaddr", err_addr, 32'h1c00_0002);
    chk("mis_cnt", {16'h0, wr_cnt}, 32'h0);
    cyc(1'b0, 32'h1c00_0000, 32'h0);
    chk("mis_rdata", rdata, 32'h0);
`else
    chk("mis_err", {31'h0, err}, 32'h0);
    chk("mis_cnt", {16'h0, wr_cnt}, 32'd1);
    cyc(1'b0, 32'h1c00_0000, 32'h0);
    chk("mis_rdata", rdata, 32'h0000_0077);
    chk("mis_err2", {31'h0, err}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the word-address width; the array holds 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h1c00_0000, giving the byte base of the array; it is aligned to 2^(ADDR_W+2).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset: asynchronous and active-high.
REQ-005 The block SHALL have port data_sram_we, input, 1 bit, the write strobe from the core; 1 means write, 0 means read.
REQ-006 The block SHALL have port data_sram_addr, input, 32 bits, the byte address.
REQ-007 The block SHALL have port data_sram_wdata, input, 32 bits, the write data.
REQ-008 The block SHALL have port data_sram_rdata, output, 32 bits, the registered read data.
REQ-009 The block SHALL have port wr_cnt, output, 16 bits, the count of accepted writes.
REQ-010 The block SHALL have port err, output, 1 bit, a sticky access-error flag.
REQ-011 The block SHALL have port err_addr, output, 32 bits, the address of the first error.

Function
REQ-012 An access SHALL be in-range iff addr[31:ADDR_W+2] equals BASE_ADDR[31:ADDR_W+2]; the word index is addr[ADDR_W+1:2].
REQ-013 Every cycle with we=0 SHALL be a read, with 1-cycle latency: data_sram_rdata, after edge N, holds the word at the address presented in cycle N.
REQ-014 Read data SHALL reflect every accepted write presented in a strictly earlier cycle.
REQ-015 In a cycle with we=1, data_sram_rdata SHALL hold its previous value.
REQ-016 The block SHALL have a one-entry store buffer (sb_valid, sb_idx, sb_data), and an accepted write SHALL load this buffer.
REQ-017 If sb_valid=1 when a new write is accepted, the old entry SHALL commit to the array on the same edge the new entry loads.
REQ-018 In a read cycle with sb_valid=1, the entry SHALL commit to the array and sb_valid SHALL clear at the edge.
REQ-019 A read whose index equals sb_idx while sb_valid=1 SHALL return sb_data (forwarding), not the array content.
REQ-020 Back-to-back writes to the same index SHALL have the last one win; a following read SHALL return the last write's data.
REQ-021 An out-of-range read SHALL return 32'h0 and SHALL set err.
REQ-022 An out-of-range write SHALL be dropped: no buffer load, no wr_cnt increment, and err set.
REQ-023 err_addr SHALL capture data_sram_addr only on the 0->1 transition of err; later errors SHALL not overwrite it.
REQ-024 wr_cnt SHALL increment by 1 per accepted write and SHALL saturate at 16'hFFFF.
REQ-025 Each cycle SHALL be decoded as exactly one access, so there are no simultaneous read/write conflicts.

Reset
REQ-026 While reset=1 (asynchronous): data_sram_rdata=0, sb_valid=0, wr_cnt=0, err=0, err_addr=0.
REQ-027 Array contents SHALL not be reset.
REQ-028 A write held in the store buffer when reset asserts SHALL be discarded, never committed.
REQ-029 The first access SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 With macro DATA_SRAM_ALIGN_CHECK_EN defined, an access with addr[1:0]!=0 SHALL be treated as an error and follow the same rules as out-of-range (REQ-021..023).
REQ-031 Without DATA_SRAM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and alignment never sets err.

Verification
REQ-032 The bench SHALL cover: reset; write 0x1c000010<-0xdeadbeef; next cycle read 0x1c000010 -> rdata=0xdeadbeef one edge later (forwarded), wr_cnt=1.
REQ-033 The bench SHALL cover: writes 0x1c000020<-0x11111111 then 0x1c000020<-0x22222222, then idle read, then read 0x1c000020 -> 0x22222222, wr_cnt=2.
REQ-034 The bench SHALL cover: write 0x1c000004<-0xa5a5a5a5, then read 0x1c000008 -> old content and buffer commits; then read 0x1c000004 -> 0xa5a5a5a5 from the array.
REQ-035 The bench SHALL cover: write to 0x00000100 -> err=1, err_addr=0x00000100, wr_cnt unchanged; then read 0x1fff0000 -> rdata=0, err_addr still 0x00000100.
REQ-036 The bench SHALL cover: write 0x1c000030<-0x5, then assert reset in the next cycle; after release, read 0x1c000030 -> not 0x5 (pre-filled 0x0), wr_cnt=0.
REQ-037 The bench SHALL cover, with DATA_SRAM_ALIGN_CHECK_EN: write 0x1c000002 -> err=1 and the write is dropped; without the macro -> the write lands at 0x1c000000 and err=0.
